// File: rtl/decode_pkg.sv
// Shared encodings for the decode pipeline: opcodes, function fields,
// ALU operation codes and control-vector bit positions.
package decode_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;

  localparam int CTRL_VALID    = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_MEMRE    = 3;
  localparam int CTRL_MEMWR    = 4;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: field extraction, legality,
// ALU code and control vector for the supported RV32I subset.
module instr_decoder
  import decode_pkg::*;
#(
  parameter int INSTR_SIZE     = 32,
  parameter int IMM_SIZE       = 32,
  parameter int NUM_A_REGS     = 32,
  parameter int ALU_OP_SIZE    = 4,
  parameter int CONTR_SIG_SIZE = 5,
  localparam int RW = $clog2(NUM_A_REGS)
) (
  input  logic [INSTR_SIZE-1:0]     instr_i,
  output logic                      legal_o,
  output logic                      use_rs1_o,
  output logic                      use_rs2_o,
  output logic [RW-1:0]             rd_o,
  output logic [RW-1:0]             rs1_o,
  output logic [RW-1:0]             rs2_o,
  output logic [IMM_SIZE-1:0]       imm_o,
  output logic [ALU_OP_SIZE-1:0]    alu_op_o,
  output logic [CONTR_SIG_SIZE-1:0] control_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    legal_o   = 1'b0;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    rd_o      = '0;
    rs1_o     = '0;
    rs2_o     = '0;
    imm_o     = '0;
    alu_op_o  = ALU_OP_SIZE'(ALU_ADD);
    control_o = '0;
    case (opcode)
      OP_R: begin
        legal_o = 1'b1;
        case (funct3)
          F3_ADD_SUB: begin
            if (funct7 == F7_BASE)     alu_op_o = ALU_OP_SIZE'(ALU_ADD);
            else if (funct7 == F7_ALT) alu_op_o = ALU_OP_SIZE'(ALU_SUB);
            else                       legal_o  = 1'b0;
          end
          F3_SRL_SRA: begin
            if (funct7 == F7_BASE)     alu_op_o = ALU_OP_SIZE'(ALU_SRL);
            else if (funct7 == F7_ALT) alu_op_o = ALU_OP_SIZE'(ALU_SRA);
            else                       legal_o  = 1'b0;
          end
          F3_SLL: begin
            alu_op_o = ALU_OP_SIZE'(ALU_SLL);
            legal_o  = (funct7 == F7_BASE);
          end
          F3_XOR: begin
            alu_op_o = ALU_OP_SIZE'(ALU_XOR);
            legal_o  = (funct7 == F7_BASE);
          end
          F3_OR: begin
            alu_op_o = ALU_OP_SIZE'(ALU_OR);
            legal_o  = (funct7 == F7_BASE);
          end
          F3_AND: begin
            alu_op_o = ALU_OP_SIZE'(ALU_AND);
            legal_o  = (funct7 == F7_BASE);
          end
          default: legal_o = 1'b0;
        endcase
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
        rd_o      = instr_i[7 +: RW];
        rs1_o     = instr_i[15 +: RW];
        rs2_o     = instr_i[20 +: RW];
        control_o[CTRL_VALID]    = 1'b1;
        control_o[CTRL_REGWRITE] = 1'b1;
      end
      OP_I, OP_LOAD: begin
        if (opcode == OP_LOAD) begin
          legal_o = (funct3 == F3_WORD);
          control_o[CTRL_MEMRE] = 1'b1;
        end else begin
          case (funct3)
            F3_ADD_SUB: begin legal_o = 1'b1; alu_op_o = ALU_OP_SIZE'(ALU_ADD); end
            F3_XOR:     begin legal_o = 1'b1; alu_op_o = ALU_OP_SIZE'(ALU_XOR); end
            F3_OR:      begin legal_o = 1'b1; alu_op_o = ALU_OP_SIZE'(ALU_OR);  end
            F3_AND:     begin legal_o = 1'b1; alu_op_o = ALU_OP_SIZE'(ALU_AND); end
            default:    legal_o = 1'b0;
          endcase
        end
        use_rs1_o = 1'b1;
        rd_o      = instr_i[7 +: RW];
        rs1_o     = instr_i[15 +: RW];
        imm_o     = {{(IMM_SIZE-12){instr_i[31]}}, instr_i[31:20]};
        control_o[CTRL_VALID]    = 1'b1;
        control_o[CTRL_REGWRITE] = 1'b1;
        control_o[CTRL_ALUSRC]   = 1'b1;
      end
      OP_STORE: begin
        legal_o   = (funct3 == F3_WORD);
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
        rs1_o     = instr_i[15 +: RW];
        rs2_o     = instr_i[20 +: RW];
        imm_o     = {{(IMM_SIZE-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        control_o[CTRL_VALID]  = 1'b1;
        control_o[CTRL_ALUSRC] = 1'b1;
        control_o[CTRL_MEMWR]  = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: registered output bundle with valid/ready handshake,
// register scoreboard for RAW/WAW stalls, illegal-instruction drop counter and flush.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int INSTR_SIZE     = 32,
  parameter int IMM_SIZE       = 32,
  parameter int NUM_A_REGS     = 32,
  parameter int ALU_OP_SIZE    = 4,
  parameter int CONTR_SIG_SIZE = 5,
  parameter int CNT_SIZE       = 16,
  localparam int RW = $clog2(NUM_A_REGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [INSTR_SIZE-1:0]     instr_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [RW-1:0]             rd_o,
  output logic [RW-1:0]             rs1_o,
  output logic [RW-1:0]             rs2_o,
  output logic [IMM_SIZE-1:0]       imm_o,
  output logic [ALU_OP_SIZE-1:0]    alu_op_o,
  output logic [CONTR_SIG_SIZE-1:0] control_o,
  input  logic                      wb_valid_i,
  input  logic [RW-1:0]             wb_rd_i,
  input  logic                      flush_i,
  output logic [CNT_SIZE-1:0]       illegal_cnt_o
);

  logic                      dec_legal, dec_use_rs1, dec_use_rs2;
  logic [RW-1:0]             dec_rd, dec_rs1, dec_rs2;
  logic [IMM_SIZE-1:0]       dec_imm;
  logic [ALU_OP_SIZE-1:0]    dec_alu_op;
  logic [CONTR_SIG_SIZE-1:0] dec_control;

  instr_decoder #(
    .INSTR_SIZE(INSTR_SIZE), .IMM_SIZE(IMM_SIZE), .NUM_A_REGS(NUM_A_REGS),
    .ALU_OP_SIZE(ALU_OP_SIZE), .CONTR_SIG_SIZE(CONTR_SIG_SIZE)
  ) u_dec (
    .instr_i(instr_i), .legal_o(dec_legal), .use_rs1_o(dec_use_rs1),
    .use_rs2_o(dec_use_rs2), .rd_o(dec_rd), .rs1_o(dec_rs1), .rs2_o(dec_rs2),
    .imm_o(dec_imm), .alu_op_o(dec_alu_op), .control_o(dec_control)
  );

  logic                      out_valid_q, out_valid_d;
  logic [RW-1:0]             rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [IMM_SIZE-1:0]       imm_q, imm_d;
  logic [ALU_OP_SIZE-1:0]    alu_op_q, alu_op_d;
  logic [CONTR_SIG_SIZE-1:0] control_q, control_d;
  logic [NUM_A_REGS-1:0]     busy_q, busy_d;
  logic [CNT_SIZE-1:0]       cnt_q, cnt_d;
  logic                      slot_free, hazard, accept, drop_illegal;

  assign slot_free = !out_valid_q || out_ready_i;

  // Writeback this cycle is deliberately not bypassed: busy_q alone decides the stall.
  assign hazard = in_valid_i && dec_legal &&
                  ((dec_use_rs1 && (dec_rs1 != '0) && busy_q[dec_rs1]) ||
                   (dec_use_rs2 && (dec_rs2 != '0) && busy_q[dec_rs2]) ||
                   (dec_control[CTRL_REGWRITE] && (dec_rd != '0) && busy_q[dec_rd]));

  assign in_ready_o   = slot_free && !hazard;
  assign accept       = in_valid_i && in_ready_o && dec_legal;
  assign drop_illegal = in_valid_i && slot_free && !dec_legal;

  always_comb begin
    out_valid_d = out_valid_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    alu_op_d    = alu_op_q;
    control_d   = control_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;

    if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;

    // A flushed cycle also discards the incoming instruction, so it never reserves rd.
    if (flush_i) begin
      out_valid_d = 1'b0;
      if (out_valid_q && control_q[CTRL_REGWRITE]) busy_d[rd_q] = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      rd_d        = dec_rd;
      rs1_d       = dec_rs1;
      rs2_d       = dec_rs2;
      imm_d       = dec_imm;
      alu_op_d    = dec_alu_op;
      control_d   = dec_control;
      if (dec_control[CTRL_REGWRITE] && (dec_rd != '0)) busy_d[dec_rd] = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    busy_d[0] = 1'b0;

    if (drop_illegal && (cnt_q != {CNT_SIZE{1'b1}})) cnt_d = cnt_q + CNT_SIZE'(1);
    else                                             cnt_d = cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      alu_op_q    <= '0;
      control_q   <= '0;
      busy_q      <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      control_q   <= control_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign rd_o          = rd_q;
  assign rs1_o         = rs1_q;
  assign rs2_o         = rs2_q;
  assign imm_o         = imm_q;
  assign alu_op_o      = alu_op_q;
  assign control_o     = control_q;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed self-checking bench for decode_pipe: handshake, scoreboard stalls,
// illegal drop counter, flush and asynchronous reset.
module tb_decode_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [31:0] imm_o;
  logic [3:0]  alu_op_o;
  logic [4:0]  control_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic [15:0] illegal_cnt_o;

  int checks = 0;
  int failures = 0;

  decode_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o), .alu_op_o(alu_op_o),
    .control_o(control_o), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .flush_i(flush_i), .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [31:0] ADD_X3   = 32'h002081B3;
  localparam logic [31:0] ADDI_X5  = 32'hFFF18293;
  localparam logic [31:0] SW_X2    = 32'h0020A423;
  localparam logic [31:0] ADDI_X0  = 32'h00100013;
  localparam logic [31:0] BAD_ALL  = 32'hFFFFFFFF;
  localparam logic [31:0] BAD_F7   = 32'h022081B3;

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid_i = 1'b0; instr_i = 32'h0; out_ready_i = 1'b1;
    wb_valid_i = 1'b0; wb_rd_i = 5'd0; flush_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({out_valid_o, rd_o, rs1_o, rs2_o, imm_o, alu_op_o, control_o} !== 57'd0) begin
      failures++; $display("FAIL reset_outputs got=%h want=0",
        {out_valid_o, rd_o, rs1_o, rs2_o, imm_o, alu_op_o, control_o});
    end
    checks++;
    if (illegal_cnt_o !== 16'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d want=0", illegal_cnt_o);
    end
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready_o);
    end
  endtask

  task automatic test_add();
    in_valid_i = 1'b1; instr_i = ADD_X3; out_ready_i = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++; $display("FAIL add_in_ready got=%b want=1", in_ready_o);
    end
    tick();
    in_valid_i = 1'b0;
    checks++;
    if ({out_valid_o, rd_o, rs1_o, rs2_o, alu_op_o, control_o, imm_o} !==
        {1'b1, 5'd3, 5'd1, 5'd2, 4'b0010, 5'b00011, 32'h0}) begin
      failures++; $display("FAIL add_bundle got v=%b rd=%0d rs1=%0d rs2=%0d alu=%b ctl=%b imm=%h want v=1 rd=3 rs1=1 rs2=2 alu=0010 ctl=00011 imm=0",
        out_valid_o, rd_o, rs1_o, rs2_o, alu_op_o, control_o, imm_o);
    end
    checks++;
    if (dut.busy_q !== 32'h0000_0008) begin
      failures++; $display("FAIL add_busy got=%h want=00000008", dut.busy_q);
    end
    tick();
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++; $display("FAIL add_drain got=%b want=0", out_valid_o);
    end
  endtask

  task automatic test_raw_stall();
    in_valid_i = 1'b1; instr_i = ADDI_X5; out_ready_i = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b0) begin
      failures++; $display("FAIL stall_initial in_ready got=%b want=0", in_ready_o);
    end
    tick(); tick();
    checks++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
      failures++; $display("FAIL stall_hold in_ready=%b out_valid=%b want 0 0", in_ready_o, out_valid_o);
    end
    wb_valid_i = 1'b1; wb_rd_i = 5'd3;
    #1;
    checks++;
    if (in_ready_o !== 1'b0) begin
      failures++; $display("FAIL stall_wb_same_cycle in_ready got=%b want=0", in_ready_o);
    end
    tick();
    wb_valid_i = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++; $display("FAIL stall_release in_ready got=%b want=1", in_ready_o);
    end
    tick();
    in_valid_i = 1'b0;
    checks++;
    if ({out_valid_o, rd_o, rs1_o, rs2_o, alu_op_o, control_o, imm_o} !==
        {1'b1, 5'd5, 5'd3, 5'd0, 4'b0010, 5'b00111, 32'hFFFFFFFF}) begin
      failures++; $display("FAIL addi_bundle got v=%b rd=%0d rs1=%0d rs2=%0d alu=%b ctl=%b imm=%h want v=1 rd=5 rs1=3 rs2=0 alu=0010 ctl=00111 imm=ffffffff",
        out_valid_o, rd_o, rs1_o, rs2_o, alu_op_o, control_o, imm_o);
    end
    checks++;
    if (dut.busy_q !== 32'h0000_0020) begin
      failures++; $display("FAIL addi_busy got=%h want=00000020", dut.busy_q);
    end
    wb_valid_i = 1'b1; wb_rd_i = 5'd5;
    tick();
    wb_valid_i = 1'b0;
    checks++;
    if (dut.busy_q !== 32'h0 || out_valid_o !== 1'b0) begin
      failures++; $display("FAIL addi_retire busy=%h out_valid=%b want 0 0", dut.busy_q, out_valid_o);
    end
  endtask

  task automatic test_store_backpressure();
    logic [46:0] first;
    in_valid_i = 1'b1; instr_i = SW_X2; out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0; instr_i = 32'h0;
    first = {rd_o, rs1_o, rs2_o, alu_op_o, control_o, imm_o[22:0]};
    checks++;
    if ({out_valid_o, rd_o, rs1_o, rs2_o, alu_op_o, control_o, imm_o} !==
        {1'b1, 5'd0, 5'd1, 5'd2, 4'b0010, 5'b10101, 32'd8}) begin
      failures++; $display("FAIL sw_bundle got v=%b rd=%0d rs1=%0d rs2=%0d alu=%b ctl=%b imm=%h want v=1 rd=0 rs1=1 rs2=2 alu=0010 ctl=10101 imm=8",
        out_valid_o, rd_o, rs1_o, rs2_o, alu_op_o, control_o, imm_o);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1; instr_i = ADD_X3;
      tick();
      checks++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 ||
          {rd_o, rs1_o, rs2_o, alu_op_o, control_o, imm_o[22:0]} !== first) begin
        failures++; $display("FAIL sw_hold cycle=%0d v=%b in_ready=%b rd=%0d ctl=%b imm=%h", i,
          out_valid_o, in_ready_o, rd_o, control_o, imm_o);
      end
    end
    in_valid_i = 1'b0;
    checks++;
    if (dut.busy_q !== 32'h0) begin
      failures++; $display("FAIL sw_busy got=%h want=0", dut.busy_q);
    end
    out_ready_i = 1'b1;
    tick();
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++; $display("FAIL sw_drain got=%b want=0", out_valid_o);
    end
  endtask

  task automatic test_x0_never_busy();
    in_valid_i = 1'b1; instr_i = ADDI_X0; out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b1 || rd_o !== 5'd0 || imm_o !== 32'd1 || dut.busy_q !== 32'h0) begin
      failures++; $display("FAIL x0_write v=%b rd=%0d imm=%h busy=%h want v=1 rd=0 imm=1 busy=0",
        out_valid_o, rd_o, imm_o, dut.busy_q);
    end
    tick();
  endtask

  task automatic test_illegal();
    in_valid_i = 1'b1; instr_i = BAD_ALL; out_ready_i = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++; $display("FAIL illegal_in_ready got=%b want=1", in_ready_o);
    end
    tick();
    checks++;
    if (out_valid_o !== 1'b0 || illegal_cnt_o !== 16'd1) begin
      failures++; $display("FAIL illegal_all_ones v=%b cnt=%0d want v=0 cnt=1", out_valid_o, illegal_cnt_o);
    end
    instr_i = BAD_F7;
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || illegal_cnt_o !== 16'd2 || dut.busy_q !== 32'h0) begin
      failures++; $display("FAIL illegal_funct7 v=%b cnt=%0d busy=%h want v=0 cnt=2 busy=0",
        out_valid_o, illegal_cnt_o, dut.busy_q);
    end
  endtask

  task automatic test_flush();
    in_valid_i = 1'b1; instr_i = ADD_X3; out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b1 || dut.busy_q !== 32'h0000_0008) begin
      failures++; $display("FAIL flush_setup v=%b busy=%h want v=1 busy=00000008", out_valid_o, dut.busy_q);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || dut.busy_q !== 32'h0) begin
      failures++; $display("FAIL flush_result v=%b busy=%h want v=0 busy=0", out_valid_o, dut.busy_q);
    end
    out_ready_i = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    in_valid_i = 1'b1; instr_i = ADD_X3; out_ready_i = 1'b0;
    tick();
    instr_i = ADDI_X5;
    tick();
    checks++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
      failures++; $display("FAIL rst_setup in_ready=%b v=%b want 0 1", in_ready_o, out_valid_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({out_valid_o, rd_o, rs1_o, rs2_o, imm_o, alu_op_o, control_o} !== 57'd0 ||
        dut.busy_q !== 32'h0 || illegal_cnt_o !== 16'd0) begin
      failures++; $display("FAIL rst_async v=%b rd=%0d ctl=%b busy=%h cnt=%0d want all 0",
        out_valid_o, rd_o, control_o, dut.busy_q, illegal_cnt_o);
    end
    idle_inputs();
    tick();
    rst_i = 1'b0;
    in_valid_i = 1'b1; instr_i = ADDI_X5;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++; $display("FAIL rst_release in_ready got=%b want=1", in_ready_o);
    end
    tick();
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b1 || rd_o !== 5'd5) begin
      failures++; $display("FAIL rst_after_accept v=%b rd=%0d want v=1 rd=5", out_valid_o, rd_o);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_raw_stall();
    test_store_backpressure();
    test_x0_never_busy();
    test_illegal();
    test_flush();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
